// File: rtl/character_mover.sv
`default_nettype none
// ============================================================================
// Module   : character_mover
// Brief    : Per-tick character movement controller (walk, jump, fall) fed by
//            the collision detector's obstacle flags and the player buttons.
// Revision : 1.0 - initial release
// ============================================================================
module character_mover #(
    parameter int START_X     = 20,
    parameter int START_Y     = 220,
    parameter int JUMP_HEIGHT = 60,
    parameter int MAX_X       = 380,
    parameter int MAX_Y       = 260
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_clock,
    input  logic       play_state,
    input  logic       collision_detect_done,
    input  logic       obs_up,
    input  logic       obs_right,
    input  logic       obs_down,
    input  logic       obs_left,
    input  logic       die,
    input  logic       reach_end,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [8:0] character_x,
    output logic [8:0] character_y,
    output logic       airborne,
    output logic       facing_left,
    output logic       moved
);

    localparam logic [1:0] ST_GROUNDED = 2'd0;
    localparam logic [1:0] ST_RISING   = 2'd1;
    localparam logic [1:0] ST_FALLING  = 2'd2;

    localparam logic [8:0] c_start_x     = 9'(START_X);
    localparam logic [8:0] c_start_y     = 9'(START_Y);
    localparam logic [8:0] c_max_x       = 9'(MAX_X);
    localparam logic [8:0] c_max_y       = 9'(MAX_Y);
    localparam logic [7:0] c_jump_height = 8'(JUMP_HEIGHT);

    logic [8:0] r_x;
    logic [8:0] r_y;
    logic [1:0] r_state;
    logic [7:0] r_rise_cnt;
    logic       r_jump_req;
    logic       r_btn_q;
    logic       r_btn_q2;
    logic       r_facing;
    logic       r_moved;

    logic       w_accept;
    logic       w_jump_rise;
    logic       w_go_right;
    logic       w_go_left;
    logic [8:0] w_y_next;
    logic [1:0] w_state_next;
    logic [7:0] w_rise_next;

    assign w_accept    = game_clock & collision_detect_done & play_state & ~die & ~reach_end;
    assign w_jump_rise = r_btn_q & ~r_btn_q2;
    assign w_go_right  = btn_right & ~btn_left & ~obs_right & (r_x < c_max_x);
    assign w_go_left   = btn_left & ~btn_right & ~obs_left & (r_x != 9'd0);

    // Vertical transition for an accepted tick; jump takes priority over walk-off.
    always_comb begin
        w_y_next     = r_y;
        w_state_next = r_state;
        w_rise_next  = r_rise_cnt;
        case (r_state)
            ST_GROUNDED: begin
                if (r_jump_req && !obs_up && (r_y != 9'd0)) begin
                    w_state_next = ST_RISING;
                    w_y_next     = r_y - 9'd1;
                    w_rise_next  = 8'd1;
                end else if (!obs_down && (r_y < c_max_y)) begin
                    w_state_next = ST_FALLING;
                end
            end
            ST_RISING: begin
                if (obs_up || (r_y == 9'd0) || (r_rise_cnt == c_jump_height)) begin
                    w_state_next = ST_FALLING;
                end else begin
                    w_y_next    = r_y - 9'd1;
                    w_rise_next = r_rise_cnt + 8'd1;
                end
            end
            default: begin
                if (obs_down || (r_y >= c_max_y)) begin
                    w_state_next = ST_GROUNDED;
                end else begin
                    w_y_next = r_y + 9'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= c_start_x;
            r_y        <= c_start_y;
            r_state    <= ST_FALLING;
            r_rise_cnt <= 8'd0;
            r_facing   <= 1'b0;
            r_moved    <= 1'b0;
        end else if (!play_state) begin
            r_x        <= c_start_x;
            r_y        <= c_start_y;
            r_state    <= ST_FALLING;
            r_rise_cnt <= 8'd0;
            r_moved    <= 1'b0;
        end else begin
            r_moved <= w_accept;
            if (w_accept) begin
                if (w_go_right) begin
                    r_x      <= r_x + 9'd1;
                    r_facing <= 1'b0;
                end else if (w_go_left) begin
                    r_x      <= r_x - 9'd1;
                    r_facing <= 1'b1;
                end
                r_y        <= w_y_next;
                r_state    <= w_state_next;
                r_rise_cnt <= w_rise_next;
            end
        end
    end

    // A fresh edge wins over the tick clear so a press coinciding with a tick
    // is still served by the following tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q    <= 1'b0;
            r_btn_q2   <= 1'b0;
            r_jump_req <= 1'b0;
        end else begin
            r_btn_q  <= btn_jump;
            r_btn_q2 <= r_btn_q;
            if (!play_state) begin
                r_jump_req <= 1'b0;
            end else if (w_jump_rise) begin
                r_jump_req <= 1'b1;
            end else if (w_accept) begin
                r_jump_req <= 1'b0;
            end
        end
    end

    assign character_x = r_x;
    assign character_y = r_y;
    assign airborne    = (r_state != ST_GROUNDED);
    assign facing_left = r_facing;
    assign moved       = r_moved;

endmodule
`default_nettype wire
